// File: rtl/lab1_idiv_pkg.sv
// Shared types and constants for the lab1 iterative divider (and its multiplier sibling).
package lab1_idiv_pkg;

  localparam int NBITS     = 32;
  localparam int COUNT_MAX = 31;
  localparam int COUNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lab1_idiv_int_div_dpath.sv
// Restoring-division datapath: remainder/quotient/divisor registers, subtractor and step counter.
// Optional two's-complement operand handling is compiled in with LAB1_IDIV_SIGNED_EN.
module lab1_idiv_int_div_dpath
  import lab1_idiv_pkg::*;
#(
  parameter int DATA_W = NBITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic                  sub_sel,
  input  logic                  out_en,
  input  logic [2*DATA_W-1:0]   req_msg,
  output logic                  diff_neg,
  output logic                  count_is_max,
  output logic [2*DATA_W-1:0]   resp_msg
);

  // The remainder's 33rd bit is always zero between steps, so only DATA_W bits are stored.
  logic [DATA_W-1:0]  r_q, r_d;
  logic [DATA_W-1:0]  q_q, q_d;
  logic [DATA_W-1:0]  d_q, d_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic [DATA_W:0]    t_w;
  logic [DATA_W:0]    diff_w;
  logic [DATA_W-1:0]  a_in, b_in, a_ld, b_ld;
  logic [DATA_W-1:0]  quo_out, rem_out;

  assign a_in = req_msg[2*DATA_W-1:DATA_W];
  assign b_in = req_msg[DATA_W-1:0];

`ifdef LAB1_IDIV_SIGNED_EN
  logic sign_a_q, sign_q_q;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    return ~x + DATA_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] x);
    return x[DATA_W-1] ? negate(x) : x;
  endfunction

  assign a_ld = abs_val(a_in);
  assign b_ld = abs_val(b_in);

  always_ff @(posedge clk) begin
    if (load) begin
      sign_a_q <= a_in[DATA_W-1];
      sign_q_q <= a_in[DATA_W-1] ^ b_in[DATA_W-1];
    end
  end

  // A zero divisor keeps the all-ones quotient unsigned-style; the remainder negation restores A.
  assign quo_out = (sign_q_q && (d_q != '0)) ? negate(q_q) : q_q;
  assign rem_out = sign_a_q ? negate(r_q) : r_q;
`else
  assign a_ld    = a_in;
  assign b_ld    = b_in;
  assign quo_out = q_q;
  assign rem_out = r_q;
`endif

  assign t_w          = {r_q, q_q[DATA_W-1]};
  assign diff_w       = t_w - {1'b0, d_q};
  assign diff_neg     = diff_w[DATA_W];
  assign count_is_max = (cnt_q == COUNT_W'(COUNT_MAX));

  always_comb begin
    r_d   = r_q;
    q_d   = q_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    if (load) begin
      r_d   = '0;
      q_d   = a_ld;
      d_d   = b_ld;
      cnt_d = '0;
    end else if (step) begin
      r_d   = sub_sel ? diff_w[DATA_W-1:0] : t_w[DATA_W-1:0];
      q_d   = {q_q[DATA_W-2:0], sub_sel};
      cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    r_q <= r_d;
    q_q <= q_d;
    d_q <= d_d;
  end

  // Output is forced to zero outside DONE so reset never exposes stale operands.
  assign resp_msg = out_en ? {rem_out, quo_out} : '0;

endmodule

// File: rtl/lab1_idiv_int_div_base.sv
// Iterative 32-step restoring divider with val/rdy request/response ports and FSM control.
// Define LAB1_IDIV_SIGNED_EN for RISC-V DIV/REM semantics; default is DIVU/REMU.
module lab1_idiv_int_div_base
  import lab1_idiv_pkg::*;
#(
  parameter int DATA_W = NBITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_val,
  output logic                req_rdy,
  input  logic [2*DATA_W-1:0] req_msg,
  output logic                resp_val,
  input  logic                resp_rdy,
  output logic [2*DATA_W-1:0] resp_msg
);

  state_t state_q, state_d;
  logic   load, step, sub_sel, diff_neg, count_is_max;

  assign req_rdy  = (state_q == IDLE) && !reset;
  assign resp_val = (state_q == DONE);
  assign load     = req_val && req_rdy;
  assign step     = (state_q == CALC);
  assign sub_sel  = step && !diff_neg;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load)         state_d = CALC;
      CALC:    if (count_is_max) state_d = DONE;
      DONE:    if (resp_rdy)     state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  lab1_idiv_int_div_dpath #(
    .DATA_W (DATA_W)
  ) u_dpath (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .step         (step),
    .sub_sel      (sub_sel),
    .out_en       (resp_val),
    .req_msg      (req_msg),
    .diff_neg     (diff_neg),
    .count_is_max (count_is_max),
    .resp_msg     (resp_msg)
  );

endmodule

// File: tb/tb_lab1_idiv_int_div_base.sv
// Self-checking bench for lab1_idiv_int_div_base: directed vector table, corner sequences, random vs. model.
module tb_lab1_idiv_int_div_base;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [63:0] req_msg;
  logic        resp_val;
  logic        resp_rdy;
  logic [63:0] resp_msg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lab1_idiv_int_div_base dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          stall;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
`ifdef LAB1_IDIV_SIGNED_EN
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
`else
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
`endif
    return {r, q};
  endfunction

  // Called away from the posedge; returns 1 time unit after the handshake edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    req_val = 1'b1;
    req_msg = {a, b};
    while (!req_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_rdy_timeout: req_rdy 0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    req_val = 1'b0;
    req_msg = {$urandom, $urandom};
  endtask

  // Waits for the response, stalls it, then completes the handshake; ends on a negedge.
  task automatic recv(input string name, input logic [63:0] exp, input int stall);
    int          edges = 0;
    logic [63:0] held;
    @(negedge clk);
    while (!resp_val && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    if (!resp_val) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: resp_val 0 after %0d cycles, required 1", name, edges);
      return;
    end
    check({name, "_latency"}, 64'(edges + 1), 64'd33);
    check(name, resp_msg, exp);
    held = resp_msg;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({name, "_stall_msg"}, resp_msg, held);
      check({name, "_stall_req_rdy"}, {63'd0, req_rdy}, 64'd0);
      check({name, "_stall_resp_val"}, {63'd0, resp_val}, 64'd1);
    end
    resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    resp_rdy = 1'b0;
    @(negedge clk);
    check({name, "_req_rdy_after"}, {63'd0, req_rdy}, 64'd1);
    check({name, "_resp_val_after"}, {63'd0, resp_val}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int          sel;
    bit          stray;

    vecs[0] = '{32'd100,        32'd7,          0, 64'h00000002_0000000E};
    vecs[1] = '{32'h0000_1234,  32'd0,          0, 64'h00001234_FFFFFFFF};
`ifdef LAB1_IDIV_SIGNED_EN
    vecs[2] = '{32'hFFFF_FFF9,  32'd2,          0, 64'hFFFFFFFF_FFFFFFFD};
    vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  0, 64'h00000000_80000000};
    vecs[7] = '{32'hDEAD_BEEF,  32'h10,         0, 64'hFFFFFFFF_FDEADBEF};
`else
    vecs[2] = '{32'hFFFF_FFF9,  32'd2,          0, 64'h00000001_7FFFFFFC};
    vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  0, 64'h80000000_00000000};
    vecs[7] = '{32'hDEAD_BEEF,  32'h10,         0, 64'h0000000F_0DEADBEE};
`endif
    vecs[4] = '{32'd5,          32'd10,         5, 64'h00000005_00000000};
    vecs[5] = '{32'hFFFF_FFFF,  32'd1,          0, 64'h00000000_FFFFFFFF};
    vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  2, 64'h00000000_00000001};

    reset    = 1'b1;
    req_val  = 1'b0;
    req_msg  = 64'd0;
    resp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_rdy", {63'd0, req_rdy}, 64'd0);
    check("reset_resp_val", {63'd0, resp_val}, 64'd0);
    check("reset_resp_msg", resp_msg, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_req_rdy", {63'd0, req_rdy}, 64'd1);

    // Directed table; vec4 stalls 5 cycles and vec5 follows back-to-back.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b);
      recv($sformatf("vec%0d", i), vecs[i].exp, vecs[i].stall);
    end

    // Asynchronous reset ten steps into CALC drops the transaction.
    send(32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midreset_resp_val", {63'd0, resp_val}, 64'd0);
    check("midreset_req_rdy", {63'd0, req_rdy}, 64'd0);
    check("midreset_resp_msg", resp_msg, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_release_req_rdy", {63'd0, req_rdy}, 64'd1);
    stray = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_val) stray = 1'b1;
    end
    check("midreset_no_response", {63'd0, stray}, 64'd0);
    send(32'd9, 32'd3);
    recv("after_reset", 64'h00000000_00000003, 0);

    for (int i = 0; i < 500; i++) begin
      a   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 32'd0;
      else if (sel < 4)  b = $urandom_range(1, 1000);
      else               b = $urandom;
      if (sel == 9) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      send(a, b);
      recv($sformatf("rand%0d", i), ref_div(a, b), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
